// File: rtl/layer_ctrl.sv
// Layer sequencer: streams image words to the layer datapath with kernel addressing and tracks results to layer completion.
// Define LAYER_CTRL_STATS_EN to build the saturating RUN-state back-pressure counter on stall_cnt.
module layer_ctrl #(
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned POOL_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_WIDTH-1:0]  cfg_mac_nb,
  input  logic [POOL_WIDTH-1:0] cfg_pool_nb,
  input  logic [CNT_WIDTH-1:0]  cfg_out_nb,
  input  logic                  cfg_val,
  output logic                  cfg_rdy,
  input  logic                  src_val,
  output logic                  src_rdy,
  output logic                  img_val,
  output logic                  img_last,
  input  logic                  img_rdy,
  output logic [CNT_WIDTH-1:0]  ker_addr,
  output logic [POOL_WIDTH-1:0] pool_nb,
  input  logic                  res_val,
  input  logic                  res_rdy,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           stall_cnt
);

  localparam int unsigned PROD_WIDTH = CNT_WIDTH + POOL_WIDTH;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    RUN   = 4'b0010,
    DRAIN = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_WIDTH-1:0]    mac_nb_q, out_nb_q;
  logic [POOL_WIDTH-1:0]   pool_nb_q;
  logic [CNT_WIDTH-1:0]    word_cnt, pix_cnt, res_cnt;
  logic [PROD_WIDTH-1:0]   pix_prod;
  logic                    cfg_acc, beat, res_beat, res_cnt_en, res_final;
  logic                    word_last, pix_final, res_last, err_set;

  assign res_beat  = res_val & res_rdy;
  assign word_last = (word_cnt == mac_nb_q - CNT_WIDTH'(1));
  assign res_last  = (res_cnt == out_nb_q - CNT_WIDTH'(1));
  assign pix_prod  = PROD_WIDTH'(out_nb_q) * PROD_WIDTH'(pool_nb_q);
  assign pix_final = (PROD_WIDTH'(pix_cnt) == pix_prod - PROD_WIDTH'(1));
  assign ker_addr  = word_cnt;
  assign pool_nb   = pool_nb_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and handshake decode
  always_comb begin
    state_nxt  = state;
    cfg_rdy    = 1'b0;
    cfg_acc    = 1'b0;
    src_rdy    = 1'b0;
    img_val    = 1'b0;
    img_last   = 1'b0;
    beat       = 1'b0;
    res_cnt_en = 1'b0;
    res_final  = 1'b0;
    err_set    = 1'b0;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE: begin
        cfg_rdy = 1'b1;
        cfg_acc = cfg_val;
        err_set = res_beat;
        if (cfg_val) state_nxt = RUN;
      end
      RUN: begin
        res_cnt_en = res_beat;
        res_final  = res_beat & res_last;
        img_val    = src_val;
        img_last   = src_val & word_last;
        // The completing result beat closes the layer, so the stream is cut in that cycle.
        src_rdy    = img_rdy & ~res_final;
        beat       = src_val & src_rdy;
        err_set    = res_final & img_last & ~pix_final;
        if (res_final)                          state_nxt = DONE;
        else if (beat && word_last && pix_final) state_nxt = DRAIN;
      end
      DRAIN: begin
        res_cnt_en = res_beat;
        res_final  = res_beat & res_last;
        if (res_final) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Latched layer configuration, zero fields clamped to 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_nb_q  <= CNT_WIDTH'(1);
      pool_nb_q <= POOL_WIDTH'(1);
      out_nb_q  <= CNT_WIDTH'(1);
    end else if (cfg_acc) begin
      mac_nb_q  <= (cfg_mac_nb == '0)  ? CNT_WIDTH'(1)  : cfg_mac_nb;
      pool_nb_q <= (cfg_pool_nb == '0) ? POOL_WIDTH'(1) : cfg_pool_nb;
      out_nb_q  <= (cfg_out_nb == '0)  ? CNT_WIDTH'(1)  : cfg_out_nb;
    end
  end

  // Word, pixel and result counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt <= '0;
      pix_cnt  <= '0;
      res_cnt  <= '0;
    end else if (cfg_acc) begin
      word_cnt <= '0;
      pix_cnt  <= '0;
      res_cnt  <= '0;
    end else begin
      if (beat) begin
        if (word_last) begin
          word_cnt <= '0;
          pix_cnt  <= pix_cnt + CNT_WIDTH'(1);
        end else begin
          word_cnt <= word_cnt + CNT_WIDTH'(1);
        end
      end
      if (res_cnt_en) res_cnt <= res_cnt + CNT_WIDTH'(1);
    end
  end

  // Sticky protocol error, cleared only when a new layer is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err <= 1'b0;
    else if (cfg_acc) err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

`ifdef LAYER_CTRL_STATS_EN
  // Saturating count of RUN cycles where upstream is held off by the datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (cfg_acc) begin
      stall_cnt <= '0;
    end else if ((state == RUN) && src_val && !img_rdy && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'(1);
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/layer_ctrl.md
LAYER_CTRL -- requirements
Module: layer_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, default 16, sets the width of the word, pixel and result counters and their config fields.
REQ-002 Parameter POOL_WIDTH, default 8, sets the width of the pool-count config field.
REQ-003 clk  input  1  single clock; all state samples on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 cfg_mac_nb  input  CNT_WIDTH  image words per MAC result (one output pixel accumulation).
REQ-006 cfg_pool_nb  input  POOL_WIDTH  MAC results per pooled result.
REQ-007 cfg_out_nb  input  CNT_WIDTH  pooled results per layer.
REQ-008 cfg_val / cfg_rdy  input / output  1 / 1  layer-start handshake.
REQ-009 src_val / src_rdy  input / output  1 / 1  upstream image-word stream handshake.
REQ-010 img_val / img_last / img_rdy  output / output / input  1 / 1 / 1  image stream to the layers datapath.
REQ-011 ker_addr  output  CNT_WIDTH  kernel-buffer word index for the current image word.
REQ-012 pool_nb  output  POOL_WIDTH  latched pool count driven to the datapath.
REQ-013 res_val / res_rdy  input / input  1 / 1  monitored result handshake; the block does not drive it.
REQ-014 busy / done / err  output / output / output  1 / 1 / 1  status.
REQ-015 stall_cnt  output  32  RUN-state back-pressure cycle count.

Function
REQ-016 States SHALL be one-hot: IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: cfg_rdy=1; on cfg_val&cfg_rdy the block latches all cfg fields, clears all counters and err, and enters RUN on the next cycle.
REQ-018 Latched zero fields SHALL be clamped to 1.
REQ-019 RUN: img_val=src_val, src_rdy=img_rdy, both combinational; a beat is src_val&img_rdy.
REQ-020 word_cnt SHALL increment per beat, and ker_addr SHALL equal word_cnt.
REQ-021 img_last=img_val&(word_cnt==mac_nb-1); on a last beat word_cnt wraps to 0 and pix_cnt increments.
REQ-022 When the last beat with pix_cnt==out_nb*pool_nb-1 occurs, the next state SHALL be DRAIN.
REQ-023 The pix_cnt comparison SHALL use a CNT_WIDTH+POOL_WIDTH product.
REQ-024 DRAIN: src_rdy=0 and img_val=0.
REQ-025 res_cnt SHALL count res_val&res_rdy beats in RUN and DRAIN.
REQ-026 When res_cnt reaches out_nb the block SHALL enter DONE, even from RUN, and src_rdy SHALL drop that cycle.
REQ-027 DONE SHALL last exactly 1 cycle with done=1, then return to IDLE.
REQ-028 busy=1 in RUN, DRAIN and DONE.
REQ-029 cfg_val outside IDLE SHALL be ignored (cfg_rdy=0).
REQ-030 err SHALL be set sticky by either of: a result beat in IDLE; a result beat in the same cycle as a last beat that completes res_cnt while pix_cnt is not final.
REQ-031 err SHALL be cleared only by a cfg accept.
REQ-032 If a beat and a result beat occur in the same cycle, both counters SHALL update.
REQ-033 pool_nb SHALL hold its latched value until the next cfg accept.

Reset
REQ-034 On rst low, asynchronously: state=IDLE, all counters=0, latched cfg=1.
REQ-035 During reset: cfg_rdy=1, src_rdy=0, img_val=0, img_last=0, ker_addr=0, pool_nb=1, busy=0, done=0, err=0, stall_cnt=0.
REQ-036 A reset mid-layer SHALL abandon the layer, with no done pulse.

Configuration
REQ-037 With LAYER_CTRL_STATS_EN defined, stall_cnt SHALL count RUN cycles with src_val&!img_rdy, saturate at 2^32-1, and clear on cfg accept.
REQ-038 Without LAYER_CTRL_STATS_EN, stall_cnt SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-039 mac_nb=4, pool_nb=2, out_nb=3, img_rdy=1, src_val=1 -> 24 beats; img_last on beats 4,8,...,24; ker_addr 0-3 repeating; 3 result beats -> done for 1 cycle.
REQ-040 mac_nb=1 -> img_last=1 on every beat and ker_addr always 0.
REQ-041 Toggle img_rdy every other cycle -> no beat lost or duplicated; with LAYER_CTRL_STATS_EN, stall_cnt equals the number of low-img_rdy cycles.
REQ-042 cfg_val pulsed during RUN -> ignored, with latched config unchanged.
REQ-043 Result beat while in IDLE -> err=1, cleared by the next cfg accept.
REQ-044 rst low after 10 beats of a 24-beat layer -> immediate IDLE and reset values; a following layer runs correctly.
